// File: rtl/lsu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_responder
// Description : MEM-stage load/store unit for the AdamRiscv pipeline. Turns
//               the decoded mem_read / mem_write / funct3 controls into a
//               single data-bus transaction on a req/gnt/rvalid bus. It
//               generates RV32I byte enables and replicates store data onto
//               the byte lanes. It extracts and sign/zero-extends load data.
//               It stalls the pipeline while the access is outstanding,
//               rejects misaligned or illegal accesses, and aborts a bus
//               that stops answering.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   clock, all state on rising edge
//   rstn         in   1   asynchronous active-low reset
//   mem_read     in   1   MEM-stage load request
//   mem_write    in   1   MEM-stage store request (wins over mem_read)
//   funct3       in   3   access size / signedness
//   addr         in  32   effective byte address
//   wdata        in  32   store data, right-aligned
//   flush        in   1   discard the current MEM-stage instruction
//   stall        out  1   hold upstream pipeline registers
//   load_data    out 32   extended load result (held between loads)
//   load_valid   out  1   one-cycle pulse, load_data valid
//   misalign     out  1   one-cycle pulse, access rejected
//   bus_err      out  1   one-cycle pulse, access aborted by timeout
//   dbus_req     out  1   bus request
//   dbus_we      out  1   1 = write
//   dbus_addr    out 32   word-aligned bus address
//   dbus_be      out  4   byte enables
//   dbus_wdata   out 32   lane-replicated store data
//   dbus_gnt     in   1   request accepted this cycle
//   dbus_rvalid  in   1   read data valid this cycle
//   dbus_rdata   in  32   read data word
// Parameter
//   TIMEOUT_CYCLES  cycles to wait for gnt or rvalid before aborting (2..255)
// ============================================================================
module lsu_mem_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The wait counter starts at 0 in the first cycle of REQ/RESP, so the
    // last permitted cycle is TIMEOUT_CYCLES-1.
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      state_q,      state_d;
    logic [7:0]  cnt_q,        cnt_d;
    logic        flushed_q,    flushed_d;
    logic [2:0]  f3_q,         f3_d;
    logic [1:0]  lane_q,       lane_d;
    logic        dbus_req_q,   dbus_req_d;
    logic        dbus_we_q,    dbus_we_d;
    logic [31:0] dbus_addr_q,  dbus_addr_d;
    logic [3:0]  dbus_be_q,    dbus_be_d;
    logic [31:0] dbus_wdata_q, dbus_wdata_d;
    logic [31:0] load_data_q,  load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        misalign_q,   misalign_d;
    logic        bus_err_q,    bus_err_d;

    // ------------------------------------------------------------------------
    // Request decode (current MEM-stage instruction)
    // ------------------------------------------------------------------------
    logic        w_access;
    logic        w_is_store;
    logic [1:0]  w_size;
    logic        w_legal_f3;
    logic        w_aligned;
    logic        w_ok;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic        w_stall;

    always_comb begin
        w_access   = mem_read | mem_write;
        // A simultaneous read+write request is handled as a store.
        w_is_store = mem_write;
        w_size     = funct3[1:0];

        // Size 11 never exists; stores have no unsigned forms; there is no
        // unsigned word load in RV32I.
        w_legal_f3 = (w_size != 2'b11)
                   && !(w_is_store && funct3[2])
                   && !(funct3[2] && (w_size == 2'b10));

        case (w_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~addr[0];
            default: w_aligned = (addr[1:0] == 2'b00);
        endcase

        w_ok = w_legal_f3 & w_aligned;

        case (w_size)
            2'b00:   w_be = 4'b0001 << addr[1:0];
            2'b01:   w_be = addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase

        // Replicating the store data means every enabled lane already holds
        // the right byte, so no barrel shifter is needed on the write path.
        case (w_size)
            2'b00:   w_wdata_rep = {4{wdata[7:0]}};
            2'b01:   w_wdata_rep = {2{wdata[15:0]}};
            default: w_wdata_rep = wdata;
        endcase
    end

    // ------------------------------------------------------------------------
    // Load extraction from the returned word (uses the latched request)
    // ------------------------------------------------------------------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    always_comb begin
        case (lane_q)
            2'd0:    w_byte = dbus_rdata[7:0];
            2'd1:    w_byte = dbus_rdata[15:8];
            2'd2:    w_byte = dbus_rdata[23:16];
            default: w_byte = dbus_rdata[31:24];
        endcase

        w_half = lane_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

        case (f3_q)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {24'h000000, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_ext = {16'h0000, w_half};
            default: w_load_ext = dbus_rdata;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flushed_d    = flushed_q;
        f3_d         = f3_q;
        lane_d       = lane_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_be_d    = dbus_be_q;
        dbus_wdata_d = dbus_wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;
        w_stall      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_access && !flush) begin
                    if (w_ok) begin
                        // Accepting cycle: stall immediately so the
                        // instruction stays in MEM until the bus finishes.
                        w_stall      = 1'b1;
                        f3_d         = funct3;
                        lane_d       = addr[1:0];
                        dbus_req_d   = 1'b1;
                        dbus_we_d    = w_is_store;
                        dbus_addr_d  = {addr[31:2], 2'b00};
                        dbus_be_d    = w_be;
                        dbus_wdata_d = w_wdata_rep;
                        flushed_d    = 1'b0;
                        cnt_d        = 8'd0;
                        state_d      = ST_REQ;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                w_stall = 1'b1;
                if (dbus_gnt) begin
                    dbus_req_d = 1'b0;
                    if (dbus_we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        // The read is already on the bus; a flush now only
                        // suppresses the write-back.
                        flushed_d = flush;
                        cnt_d     = 8'd0;
                        state_d   = ST_RESP;
                    end
                end else if (flush) begin
                    dbus_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (cnt_q == c_timeout_last) begin
                    dbus_req_d = 1'b0;
                    bus_err_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_RESP: begin
                w_stall = 1'b1;
                if (dbus_rvalid) begin
                    state_d = ST_IDLE;
                    if (!(flushed_q || flush)) begin
                        load_data_d  = w_load_ext;
                        load_valid_d = 1'b1;
                    end
                end else begin
                    if (flush) begin
                        flushed_d = 1'b1;
                    end
                    if (cnt_q == c_timeout_last) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            default: begin
                dbus_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            flushed_q    <= 1'b0;
            f3_q         <= 3'b000;
            lane_q       <= 2'b00;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= 32'h0000_0000;
            dbus_be_q    <= 4'b0000;
            dbus_wdata_q <= 32'h0000_0000;
            load_data_q  <= 32'h0000_0000;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flushed_q    <= flushed_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_be_q    <= dbus_be_d;
            dbus_wdata_q <= dbus_wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // stall is combinational (it must rise in the accepting cycle), so it is
    // gated with rstn to keep every output low while reset is asserted.
    assign stall      = rstn & w_stall;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign misalign   = misalign_q;
    assign bus_err    = bus_err_q;
    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_be    = dbus_be_q;
    assign dbus_wdata = dbus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_responder
// Description : Self-checking bench for lsu_mem_responder. Directed scenarios
//               followed by randomized instruction/bus traffic, all compared
//               every cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_responder;

    localparam int TO = 4;

    logic        clk;
    logic        rstn;
    logic        mem_read, mem_write, flush;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, load_valid, misalign, bus_err;
    logic [31:0] load_data;
    logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;

    lsu_mem_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .flush(flush),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .misalign(misalign), .bus_err(bus_err),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: one outstanding transaction record
    // ------------------------------------------------------------------------
    typedef struct {
        bit          active;   // transaction owns the bus / pipeline
        bit          granted;  // request phase over, waiting for data
        bit          killed;   // write-back suppressed by a flush
        bit          store;
        int          waited;   // cycles already spent in the current phase
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wbus;
    } txn_t;

    txn_t        t;
    logic [31:0] e_load_data;
    bit          e_lv, e_mis, e_err;

    // Observation counters (reset per directed scenario)
    int          stall_cnt, lv_cnt, mis_cnt, err_cnt, req_cnt;
    logic [3:0]  last_be;
    logic [31:0] last_wd;
    logic        last_we;

    function automatic int nbytes_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit legal_access(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'd3) return 1'b0;
        if (st && f3[2]) return 1'b0;
        if (f3[2] && nbytes_of(f3) == 4) return 1'b0;
        return (a % nbytes_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] expect_load(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] word);
        logic [31:0] mask, v;
        int          n;
        n = nbytes_of(f3);
        if (n == 4) return word;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (word >> (8 * (a % 4))) & mask;
        if (!f3[2] && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    function automatic bit exp_stall();
        if (t.active) return 1'b1;
        return (mem_read || mem_write) && !flush && legal_access(mem_write, funct3, addr);
    endfunction

    task automatic model_reset();
        t.active = 0; t.granted = 0; t.killed = 0; t.store = 0; t.waited = 0;
        t.f3 = '0; t.addr = '0; t.be = '0; t.wbus = '0;
        e_load_data = '0; e_lv = 0; e_mis = 0; e_err = 0;
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        int n;
        e_lv = 0; e_mis = 0; e_err = 0;
        if (!t.active) begin
            if ((mem_read || mem_write) && !flush) begin
                if (legal_access(mem_write, funct3, addr)) begin
                    n = nbytes_of(funct3);
                    t.active = 1; t.granted = 0; t.killed = 0; t.waited = 0;
                    t.store = mem_write; t.f3 = funct3; t.addr = addr;
                    t.be = 4'(((1 << n) - 1) << (addr % 4));
                    if (n == 1)      t.wbus = (wdata & 32'hFF) * 32'h0101_0101;
                    else if (n == 2) t.wbus = (wdata & 32'hFFFF) * 32'h0001_0001;
                    else             t.wbus = wdata;
                end else begin
                    e_mis = 1;
                end
            end
        end else if (!t.granted) begin
            if (dbus_gnt) begin
                if (t.store) t.active = 0;
                else begin t.granted = 1; t.waited = 0; t.killed = flush; end
            end else if (flush) begin
                t.active = 0;
            end else if (t.waited == TO - 1) begin
                t.active = 0; e_err = 1;
            end else begin
                t.waited++;
            end
        end else begin
            if (dbus_rvalid) begin
                t.active = 0;
                if (!(t.killed || flush)) begin
                    e_lv = 1;
                    e_load_data = expect_load(t.f3, t.addr, dbus_rdata);
                end
            end else begin
                if (flush) t.killed = 1;
                if (t.waited == TO - 1) begin t.active = 0; e_err = 1; end
                else t.waited++;
            end
        end
    endtask

    task automatic check_outputs();
        bit req_exp;
        req_exp = t.active && !t.granted;
        check("stall", stall, exp_stall());
        check("dbus_req", dbus_req, req_exp);
        if (req_exp) begin
            check("dbus_we", dbus_we, t.store);
            check("dbus_addr", dbus_addr, t.addr & 32'hFFFF_FFFC);
            check("dbus_be", dbus_be, t.be);
            if (t.store) check("dbus_wdata", dbus_wdata, t.wbus);
        end
        check("load_valid", load_valid, e_lv);
        if (e_lv) check("load_data", load_data, e_load_data);
        check("misalign", misalign, e_mis);
        check("bus_err", bus_err, e_err);
        stall_cnt += stall; lv_cnt += load_valid; mis_cnt += misalign;
        err_cnt += bus_err; req_cnt += dbus_req;
        if (dbus_req) begin last_be = dbus_be; last_wd = dbus_wdata; last_we = dbus_we; end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr_counts();
        stall_cnt = 0; lv_cnt = 0; mis_cnt = 0; err_cnt = 0; req_cnt = 0;
        last_be = '0; last_wd = '0; last_we = 0;
    endtask

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; flush = 0; dbus_gnt = 0; dbus_rvalid = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_load_valid"}, load_valid, 0);
        check({tag, "_misalign"}, misalign, 0);
        check({tag, "_bus_err"}, bus_err, 0);
        check({tag, "_dbus_req"}, dbus_req, 0);
        check({tag, "_dbus_we"}, dbus_we, 0);
        check({tag, "_dbus_be"}, dbus_be, 0);
        check({tag, "_dbus_addr"}, dbus_addr, 0);
        check({tag, "_dbus_wdata"}, dbus_wdata, 0);
        check({tag, "_load_data"}, load_data, 0);
    endtask

    // One access with grant after gdly waiting cycles and data right after grant.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gdly, input logic [31:0] rdat);
        clr_counts();
        idle_inputs();
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        cycle();
        if (t.active) begin
            repeat (gdly) cycle();
            dbus_gnt = 1; cycle(); dbus_gnt = 0;
            if (t.active) begin
                dbus_rvalid = 1; dbus_rdata = rdat; cycle(); dbus_rvalid = 0;
            end
        end
        idle_inputs();
        cycle();
    endtask

    logic [2:0] legal_f3 [5];

    initial begin
        legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rstn = 0; idle_inputs();
        funct3 = 3'b010; addr = 32'h100; wdata = '0; dbus_rdata = '0;
        model_reset(); clr_counts();

        // Reset state, with a valid load presented to prove stall is gated
        mem_read = 1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        mem_read = 0;
        @(negedge clk); rstn = 1;
        @(posedge clk); #1;

        // LW 0x100: 3-cycle load
        access(1, 0, 3'b010, 32'h100, 0, 0, 32'hDEAD_BEEF);
        check("lw_data", load_data, 32'hDEAD_BEEF);
        check("lw_valid_pulses", lv_cnt, 1);
        check("lw_stall_cycles", stall_cnt, 3);
        check("lw_be", last_be, 4'hF);

        // Byte / half loads with extension
        access(1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF_FFFF);
        check("lb_data", load_data, 32'hFFFF_FF80);
        access(1, 0, 3'b100, 32'h103, 0, 0, 32'h80FF_FFFF);
        check("lbu_data", load_data, 32'h0000_0080);
        access(1, 0, 3'b001, 32'h102, 0, 0, 32'h8001_1234);
        check("lh_data", load_data, 32'hFFFF_8001);

        // SB 0x101 with grant held off for 3 cycles
        access(0, 1, 3'b000, 32'h101, 32'h0000_00AB, 3, 0);
        check("sb_req_cycles", req_cnt, 4);
        check("sb_be", last_be, 4'b0010);
        check("sb_wdata", last_wd, 32'hABAB_ABAB);
        check("sb_we", last_we, 1);
        check("sb_stall_cycles", stall_cnt, 5);
        check("sb_no_load_valid", lv_cnt, 0);

        // Misaligned LW and SH
        access(1, 0, 3'b010, 32'h102, 0, 0, 0);
        check("lw_mis_pulses", mis_cnt, 1);
        check("lw_mis_req", req_cnt, 0);
        check("lw_mis_stall", stall_cnt, 0);
        access(0, 1, 3'b001, 32'h201, 32'h1234, 0, 0);
        check("sh_mis_pulses", mis_cnt, 1);
        check("sh_mis_req", req_cnt, 0);
        check("sh_mis_stall", stall_cnt, 0);

        // Timeout in RESP, then a stray late rvalid
        clr_counts(); idle_inputs();
        mem_read = 1; funct3 = 3'b010; addr = 32'h40;
        cycle();
        dbus_gnt = 1; cycle(); dbus_gnt = 0;
        repeat (TO) cycle();
        idle_inputs();
        cycle();
        dbus_rvalid = 1; dbus_rdata = 32'h1111_2222; cycle(); dbus_rvalid = 0;
        cycle();
        check("to_bus_err_pulses", err_cnt, 1);
        check("to_stall_cycles", stall_cnt, 2 + TO);
        check("to_stray_rvalid", lv_cnt, 0);

        // Flush in REQ before grant
        clr_counts(); idle_inputs();
        mem_read = 1; funct3 = 3'b010; addr = 32'h80;
        cycle();
        flush = 1; cycle();
        idle_inputs(); cycle(); cycle();
        check("fr_req_cycles", req_cnt, 1);
        check("fr_pulses", lv_cnt + mis_cnt + err_cnt, 0);
        check("fr_stall_cycles", stall_cnt, 2);

        // Flush in RESP: data consumed, write-back suppressed
        clr_counts(); idle_inputs();
        mem_read = 1; funct3 = 3'b010; addr = 32'h84;
        cycle();
        dbus_gnt = 1; cycle(); dbus_gnt = 0;
        flush = 1; cycle(); flush = 0;
        dbus_rvalid = 1; dbus_rdata = 32'h5555_AAAA; cycle();
        idle_inputs(); cycle();
        check("fp_load_valid", lv_cnt, 0);
        check("fp_stall_cycles", stall_cnt, 4);
        check("fp_load_data_held", load_data, 32'hFFFF_8001);

        // Asynchronous reset in the middle of RESP
        idle_inputs();
        mem_read = 1; funct3 = 3'b010; addr = 32'h88;
        cycle();
        dbus_gnt = 1; cycle(); dbus_gnt = 0;
        #2 rstn = 0;
        #1 check_all_zero("rst_resp");
        @(posedge clk); #1;
        rstn = 1; idle_inputs(); model_reset();
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!t.active) begin
                int r;
                r = $urandom_range(0, 99);
                mem_read = 0; mem_write = 0;
                if (r < 35)      mem_read = 1;
                else if (r < 65) mem_write = 1;
                else if (r < 70) begin mem_read = 1; mem_write = 1; end
                if ($urandom_range(0, 3) == 0) funct3 = 3'($urandom);
                else                           funct3 = legal_f3[$urandom_range(0, 4)];
                addr = $urandom;
                if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
                wdata = $urandom;
            end
            flush       = ($urandom_range(0, 99) < 4);
            dbus_gnt    = ($urandom_range(0, 99) < 40);
            dbus_rvalid = ($urandom_range(0, 99) < 40);
            dbus_rdata  = $urandom;
            cycle();
        end
        idle_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
